miss_fill_ctrl: RTL and testbench

- Cache miss handler for the 8-way set-associative cache; sits directly downstream of the FIFO replacement unit and consumes its 3-bit victim way.
- On a miss it captures the victim way and pulses the replacement unit's update strobe.
- If the victim line is dirty, it writes the victim back to memory word by word. It then fetches the missing line from memory, writes it into the data array, and updates tag/valid/dirty for the victim way.
- Single outstanding miss; req/ack memory handshake.

---
 rtl/miss_fill_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_miss_fill_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_fill_ctrl.sv
// miss_fill_ctrl
// Miss handler for the 8-way set-associative cache. It accepts one miss at a
// time and takes the victim way from the FIFO replacement unit. When the
// victim line is dirty, it writes the line back to memory one word at a time.
// It then fetches the missing line, writes it into the data array, and
// rewrites the tag/state entry of the victim way.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   miss              miss reported by the tag compare (ignored while busy)
//   miss_tag/idx      address of the missing line
//   victim            victim way from the replacement unit
//   victim_dirty      victim line needs a writeback
//   victim_tag        tag held in the victim way (writeback address)
//   busy              controller occupied, upstream stalls
//   repl_upd          one-cycle strobe: victim consumed
//   mem_*             word-wide req/ack memory port, address {tag, idx, off}
//   arr_*             data-array port (read has one cycle of latency)
//   tag_we/tag_wdata  tag/state write for the victim way (valid=1, dirty=0)
//   done              one-cycle pulse when the fill completes
module miss_fill_ctrl #(
    parameter int TAG_W  = 8,
    parameter int IDX_W  = 2,
    parameter int OFF_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         miss,
    input  logic [TAG_W-1:0]             miss_tag,
    input  logic [IDX_W-1:0]             miss_idx,
    input  logic [2:0]                   victim,
    input  logic                         victim_dirty,
    input  logic [TAG_W-1:0]             victim_tag,
    output logic                         busy,
    output logic                         repl_upd,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [TAG_W+IDX_W+OFF_W-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         arr_rd_en,
    input  logic [DATA_W-1:0]            arr_rdata,
    output logic                         arr_we,
    output logic [2:0]                   arr_way,
    output logic [IDX_W-1:0]             arr_idx,
    output logic [OFF_W-1:0]             arr_off,
    output logic [DATA_W-1:0]            arr_wdata,
    output logic                         tag_we,
    output logic [TAG_W-1:0]             tag_wdata,
    output logic                         done
);

    localparam logic [OFF_W-1:0] LAST_K = '1;
    localparam logic [OFF_W-1:0] ONE_K  = OFF_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_REQ,
        FILL,
        TAG_UPD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [OFF_W-1:0]    k;
    logic [OFF_W-1:0]    k_next;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    vtag_q;
    logic [IDX_W-1:0]    idx_q;
    logic [2:0]          way_q;
    logic                wb_first;
    logic [DATA_W-1:0]   wb_data_q;
    logic [DATA_W-1:0]   wb_word;

    // The array returns read data in the first WB_REQ cycle. In that cycle
    // the word is passed straight through, so a zero-wait ack can complete it
    // at once. The word is also captured at that point, which keeps mem_wdata
    // stable even after the array output changes during later wait states.
    assign wb_word = wb_first ? arr_rdata : wb_data_q;

    // This block holds the state register, the word counter, and the miss
    // context latched when a miss is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            tag_q     <= '0;
            vtag_q    <= '0;
            idx_q     <= '0;
            way_q     <= '0;
            wb_first  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            wb_first <= (state == WB_RD);
            if (state == WB_REQ && wb_first) begin
                wb_data_q <= arr_rdata;
            end
            if (state == IDLE && miss) begin
                tag_q  <= miss_tag;
                vtag_q <= victim_tag;
                idx_q  <= miss_idx;
                way_q  <= victim;
            end
        end
    end

    // This block computes the next state and all outputs. Every output is
    // forced low while reset is high, so an interrupted transfer cannot leave
    // a stray strobe asserted in the reset cycle.
    always_comb begin
        state_next = state;
        k_next     = k;
        busy       = 1'b0;
        repl_upd   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arr_rd_en  = 1'b0;
        arr_we     = 1'b0;
        arr_way    = '0;
        arr_idx    = '0;
        arr_off    = '0;
        arr_wdata  = '0;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        done       = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        repl_upd   = 1'b1;
                        k_next     = '0;
                        state_next = victim_dirty ? WB_RD : FILL;
                    end
                end

                WB_RD: begin
                    busy       = 1'b1;
                    arr_rd_en  = 1'b1;
                    arr_way    = way_q;
                    arr_idx    = idx_q;
                    arr_off    = k;
                    state_next = WB_REQ;
                end

                WB_REQ: begin
                    busy      = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {vtag_q, idx_q, k};
                    mem_wdata = wb_word;
                    if (mem_ack) begin
                        if (k == LAST_K) begin
                            k_next     = '0;
                            state_next = FILL;
                        end else begin
                            k_next     = k + ONE_K;
                            state_next = WB_RD;
                        end
                    end
                end

                FILL: begin
                    busy     = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {tag_q, idx_q, k};
                    arr_way  = way_q;
                    arr_idx  = idx_q;
                    arr_off  = k;
                    if (mem_ack) begin
                        arr_we    = 1'b1;
                        arr_wdata = mem_rdata;
                        // The counter stays on the last word. It is cleared
                        // when the next miss is accepted.
                        if (k == LAST_K) begin
                            state_next = TAG_UPD;
                        end else begin
                            k_next = k + ONE_K;
                        end
                    end
                end

                TAG_UPD: begin
                    busy       = 1'b1;
                    tag_we     = 1'b1;
                    tag_wdata  = tag_q;
                    done       = 1'b1;
                    state_next = IDLE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miss_fill_ctrl.sv
// tb_miss_fill_ctrl
// Scoreboard bench for miss_fill_ctrl. Each miss that is driven pushes its
// expected memory transactions, array writes and tag update onto queues. A
// monitor pops and compares these entries as the DUT produces them.
module tb_miss_fill_ctrl;

    localparam int TAG_W  = 8;
    localparam int IDX_W  = 2;
    localparam int OFF_W  = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_txn_t;

    typedef struct {
        logic [2:0]        way;
        logic [IDX_W-1:0]  idx;
        logic [OFF_W-1:0]  off;
        logic [DATA_W-1:0] data;
    } arr_txn_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               lat;
    } done_txn_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                miss;
    logic [TAG_W-1:0]    miss_tag;
    logic [IDX_W-1:0]    miss_idx;
    logic [2:0]          victim;
    logic                victim_dirty;
    logic [TAG_W-1:0]    victim_tag;
    logic                busy;
    logic                repl_upd;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                arr_rd_en;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_we;
    logic [2:0]          arr_way;
    logic [IDX_W-1:0]    arr_idx;
    logic [OFF_W-1:0]    arr_off;
    logic [DATA_W-1:0]   arr_wdata;
    logic                tag_we;
    logic [TAG_W-1:0]    tag_wdata;
    logic                done;

    logic [DATA_W-1:0]   fill_base = 8'hA0;
    logic [DATA_W-1:0]   arr_base  = 8'h50;
    int                  wait_states = 0;
    int                  wait_cnt = 0;
    logic                spurious_ack = 1'b0;

    mem_txn_t            mem_q[$];
    arr_txn_t            arr_q[$];
    done_txn_t           done_q[$];

    int                  pass_cnt = 0;
    int                  total_cnt = 0;
    int                  cycle = 0;
    int                  accept_cycle = 0;
    int                  repl_cnt = 0;
    int                  tag_cnt = 0;
    logic                prev_wait = 1'b0;
    logic [ADDR_W-1:0]   prev_addr;
    logic [DATA_W-1:0]   prev_wdata;
    logic                prev_we;

    always #5 clk = ~clk;

    miss_fill_ctrl #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .miss        (miss),
        .miss_tag    (miss_tag),
        .miss_idx    (miss_idx),
        .victim      (victim),
        .victim_dirty(victim_dirty),
        .victim_tag  (victim_tag),
        .busy        (busy),
        .repl_upd    (repl_upd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .arr_rd_en   (arr_rd_en),
        .arr_rdata   (arr_rdata),
        .arr_we      (arr_we),
        .arr_way     (arr_way),
        .arr_idx     (arr_idx),
        .arr_off     (arr_off),
        .arr_wdata   (arr_wdata),
        .tag_we      (tag_we),
        .tag_wdata   (tag_wdata),
        .done        (done)
    );

    // Memory model: it acks after wait_states full cycles of request, and
    // with zero wait states it acks in the same cycle. Read data is
    // fill_base plus the word offset.
    assign mem_ack   = (mem_req && (wait_cnt == wait_states)) || spurious_ack;
    assign mem_rdata = fill_base + DATA_W'(mem_addr[OFF_W-1:0]);

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Data-array model: the read returns arr_base plus the offset one cycle
    // after arr_rd_en.
    always @(posedge clk) begin
        if (arr_rd_en) arr_rdata <= arr_base + DATA_W'(arr_off);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Monitor: it samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                checkOutput("req_held", mem_req, 1'b1);
                checkOutput("addr_stable", mem_addr, prev_addr);
                checkOutput("we_stable", mem_we, prev_we);
                checkOutput("wdata_stable", mem_wdata, prev_wdata);
            end
            prev_wait  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_we    = mem_we;

            if (repl_upd) begin
                accept_cycle = cycle;
                repl_cnt++;
            end
            if (mem_req && mem_ack) begin
                if (mem_q.size() == 0) begin
                    checkOutput("mem_unexpected", 1, 0);
                end else begin
                    mem_txn_t e;
                    e = mem_q.pop_front();
                    checkOutput("mem_we", mem_we, e.we);
                    checkOutput("mem_addr", mem_addr, e.addr);
                    if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (arr_we) begin
                if (arr_q.size() == 0) begin
                    checkOutput("arr_unexpected", 1, 0);
                end else begin
                    arr_txn_t a;
                    a = arr_q.pop_front();
                    checkOutput("arr_way", arr_way, a.way);
                    checkOutput("arr_idx", arr_idx, a.idx);
                    checkOutput("arr_off", arr_off, a.off);
                    checkOutput("arr_wdata", arr_wdata, a.data);
                end
            end
            if (tag_we) begin
                tag_cnt++;
                checkOutput("done_with_tag", done, 1'b1);
                if (done_q.size() == 0) begin
                    checkOutput("tag_unexpected", 1, 0);
                end else begin
                    done_txn_t d;
                    d = done_q.pop_front();
                    checkOutput("tag_wdata", tag_wdata, d.tag);
                    checkOutput("latency", cycle - accept_cycle, d.lat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // This task pushes the full expected transaction sequence for one miss
    // and presents the miss to the DUT.
    task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                                 input logic [2:0] way, input logic dirty,
                                 input logic [TAG_W-1:0] vtag);
        logic [OFF_W-1:0] o;
        mem_txn_t m;
        arr_txn_t a;
        done_txn_t d;
        if (dirty) begin
            for (int i = 0; i < 4; i++) begin
                o = OFF_W'(i);
                m.we = 1'b1; m.addr = {vtag, idx, o}; m.wdata = arr_base + DATA_W'(o);
                mem_q.push_back(m);
            end
        end
        for (int i = 0; i < 4; i++) begin
            o = OFF_W'(i);
            m.we = 1'b0; m.addr = {tag, idx, o}; m.wdata = '0;
            mem_q.push_back(m);
            a.way = way; a.idx = idx; a.off = o; a.data = fill_base + DATA_W'(o);
            arr_q.push_back(a);
        end
        d.tag = tag;
        d.lat = dirty ? (13 + 8 * wait_states) : (5 + 4 * wait_states);
        done_q.push_back(d);
        miss_tag     = tag;
        miss_idx     = idx;
        victim       = way;
        victim_dirty = dirty;
        victim_tag   = vtag;
        miss         = 1'b1;
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (tag_cnt < target && n < 400) begin
            step();
            n++;
        end
        if (tag_cnt < target) checkOutput("done_timeout", tag_cnt, target);
    endtask

    task automatic runMiss(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                           input logic [2:0] way, input logic dirty,
                           input logic [TAG_W-1:0] vtag);
        int target;
        int r0;
        target = tag_cnt + 1;
        r0 = repl_cnt;
        applyStimulus(tag, idx, way, dirty, vtag);
        step();
        miss = 1'b0;
        waitDone(target);
        step();
        checkOutput("repl_once", repl_cnt - r0, 1);
        checkOutput("mem_q_drained", mem_q.size(), 0);
        checkOutput("arr_q_drained", arr_q.size(), 0);
        checkOutput("busy_after", busy, 1'b0);
    endtask

    function automatic logic [63:0] allOutputs();
        return {13'd0, busy, repl_upd, mem_req, mem_we, mem_addr, mem_wdata, arr_rd_en,
                arr_we, arr_way, arr_idx, arr_off, arr_wdata, tag_we, tag_wdata, done};
    endfunction

    initial begin
        int n;
        int t0;
        reset = 1'b1; miss = 1'b0; miss_tag = '0; miss_idx = '0;
        victim = '0; victim_dirty = 1'b0; victim_tag = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        checkOutput("reset_outputs", allOutputs(), 64'd0);

        $display("[TB] clean miss, zero wait");
        runMiss(8'h3C, 2'd1, 3'd5, 1'b0, 8'h00);

        $display("[TB] dirty miss, zero wait");
        runMiss(8'h77, 2'd2, 3'd3, 1'b1, 8'h11);

        $display("[TB] wait states, clean and dirty");
        wait_states = 3;
        runMiss(8'h5A, 2'd3, 3'd1, 1'b0, 8'h00);
        runMiss(8'hC4, 2'd0, 3'd6, 1'b1, 8'h2B);
        wait_states = 0;

        $display("[TB] miss held high through a fill");
        t0 = repl_cnt;
        applyStimulus(8'h9E, 2'd1, 3'd2, 1'b0, 8'h00);
        applyStimulus(8'h9E, 2'd1, 3'd2, 1'b0, 8'h00);
        waitDone(tag_cnt + 1);
        checkOutput("held_single_repl", repl_cnt - t0, 1);
        checkOutput("held_reaccept", repl_upd, 1'b1);
        step();
        miss = 1'b0;
        waitDone(2 + (tag_cnt - 1));
        step();
        checkOutput("held_total_repl", repl_cnt - t0, 2);

        $display("[TB] spurious ack in IDLE");
        t0 = tag_cnt;
        spurious_ack = 1'b1;
        #1;
        checkOutput("spur_arr_we", arr_we, 1'b0);
        step();
        spurious_ack = 1'b0;
        checkOutput("spur_busy", busy, 1'b0);
        checkOutput("spur_req", mem_req, 1'b0);
        repeat (3) step();
        checkOutput("spur_no_tag", tag_cnt - t0, 0);

        $display("[TB] reset during fill at word 2");
        wait_states = 3;
        applyStimulus(8'h42, 2'd2, 3'd4, 1'b0, 8'h00);
        step();
        miss = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we && mem_addr[OFF_W-1:0] == 2'd2) && n < 100) begin
            step();
            n++;
        end
        checkOutput("reached_k2", mem_addr[OFF_W-1:0], 2'd2);
        reset = 1'b1;
        mem_q.delete();
        arr_q.delete();
        done_q.delete();
        t0 = tag_cnt;
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("abort_outputs", allOutputs(), 64'd0);
        repeat (20) step();
        checkOutput("abort_no_tag", tag_cnt - t0, 0);
        checkOutput("abort_busy", busy, 1'b0);
        wait_states = 0;

        $display("[TB] clean miss after abort");
        runMiss(8'h3C, 2'd1, 3'd5, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
